// File: rtl/lcd_timing_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// lcd_timing_pkg
// Purpose : shared LCD timing constants (the parameter defaults), port widths
//           and the PPU mode encoding used by the timing controller.
// Ports   : none (package).
// ----------------------------------------------------------------------------
package lcd_timing_pkg;

   // Default timing of a 456-dot x 154-line frame
   localparam int unsigned DOTS_PER_LINE_DEF   = 456;
   localparam int unsigned LINES_PER_FRAME_DEF = 154;
   localparam int unsigned VISIBLE_LINES_DEF   = 144;
   localparam int unsigned OAM_DOTS_DEF        = 80;
   localparam int unsigned DRAW_DOTS_DEF       = 172;

   // Port widths
   localparam int unsigned DOT_W = 9;
   localparam int unsigned LY_W  = 8;
   localparam int unsigned SCX_W = 3;
   localparam int unsigned IE_W  = 4;

   // STAT mode field encoding
   typedef enum logic [1:0] {
      HBLANK = 2'd0,
      VBLANK = 2'd1,
      OAM    = 2'd2,
      DRAW   = 2'd3
   } lcd_mode_e;

endpackage

// File: rtl/lcd_timing_ctrl_if.sv
// ----------------------------------------------------------------------------
// lcd_timing_ctrl_if
// Purpose : register-side bundle between the CPU register file and the LCD
//           timing controller.
// Signals : lcd_en, lyc, scx_lo, stat_ie      (register file -> controller)
//           ly, dot, mode, lyc_eq,
//           irq_vblank, irq_stat             (controller -> register file)
// Modports: master = register file side, slave = timing controller side.
// ----------------------------------------------------------------------------
interface lcd_timing_ctrl_if;
   import lcd_timing_pkg::*;

   logic              lcd_en;
   logic [LY_W-1:0]   lyc;
   logic [SCX_W-1:0]  scx_lo;
   logic [IE_W-1:0]   stat_ie;

   logic [LY_W-1:0]   ly;
   logic [DOT_W-1:0]  dot;
   logic [1:0]        mode;
   logic              lyc_eq;
   logic              irq_vblank;
   logic              irq_stat;

   modport master (
      output lcd_en, lyc, scx_lo, stat_ie,
      input  ly, dot, mode, lyc_eq, irq_vblank, irq_stat
   );

   modport slave (
      input  lcd_en, lyc, scx_lo, stat_ie,
      output ly, dot, mode, lyc_eq, irq_vblank, irq_stat
   );

endinterface

// File: rtl/lcd_timing_ctrl_stat_irq.sv
// ----------------------------------------------------------------------------
// lcd_stat_irq
// Purpose : STAT interrupt edge detector. Emits a one-clk pulse on a 0->1
//           edge of the OR-ed STAT line; a source handing over to another
//           source with no low gap keeps the line high and gives no pulse.
// Ports   : clk, reset   - dot clock, async active-high reset
//           stat_line    - combined STAT request line
//           clr          - hold history and pulse at zero
//           pulse        - registered one-clk interrupt request
// ----------------------------------------------------------------------------
module lcd_stat_irq (
   input  logic clk,
   input  logic reset,
   input  logic stat_line,
   input  logic clr,
   output logic pulse
);

   logic line_q, line_d;
   logic pulse_q, pulse_d;

   // Edge history and pulse next-state
   always_comb begin
      line_d  = 1'b0;
      pulse_d = 1'b0;
      if (!clr) begin
         line_d  = stat_line;
         pulse_d = stat_line & ~line_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         line_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         line_q  <= line_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/lcd_timing_ctrl.sv
// ----------------------------------------------------------------------------
// lcd_timing_ctrl
// Purpose : LCD dot/line timing generator. Counts dots and lines, derives the
//           PPU mode (OAM/DRAW/HBLANK/VBLANK), the LY==LYC flag and the
//           VBLANK and STAT interrupt pulses. All outputs are registered.
// Ports   : clk   - dot clock
//           reset - async active-high reset
//           bus   - lcd_timing_ctrl_if.slave (lcd_en, lyc, scx_lo, stat_ie in;
//                   ly, dot, mode, lyc_eq, irq_vblank, irq_stat out)
// ----------------------------------------------------------------------------
module lcd_timing_ctrl
   import lcd_timing_pkg::*;
#(
   parameter int unsigned DOTS_PER_LINE   = DOTS_PER_LINE_DEF,
   parameter int unsigned LINES_PER_FRAME = LINES_PER_FRAME_DEF,
   parameter int unsigned VISIBLE_LINES   = VISIBLE_LINES_DEF,
   parameter int unsigned OAM_DOTS        = OAM_DOTS_DEF,
   parameter int unsigned DRAW_DOTS       = DRAW_DOTS_DEF
) (
   input  logic              clk,
   input  logic              reset,
   lcd_timing_ctrl_if.slave  bus
);

   localparam int unsigned DRAW_END = OAM_DOTS + DRAW_DOTS;

   logic [DOT_W-1:0] dot_q, dot_d;
   logic [LY_W-1:0]  ly_q, ly_d;
   lcd_mode_e        mode_q, mode_d;
   logic [SCX_W-1:0] pen_q, pen_d;
   logic             run_q, run_d;
   logic             lyc_eq_q, lyc_eq_d;
   logic             irq_vblank_q, irq_vblank_d;
   logic             stat_line_c;
   logic             stat_clr_c;
   logic             irq_stat_c;

   // Next-state: counters, mode and pen are decoded from the new dot/ly so
   // that mode moves in the same clk as the position that causes it.
   always_comb begin
      dot_d        = dot_q;
      ly_d         = ly_q;
      mode_d       = mode_q;
      pen_d        = pen_q;
      run_d        = run_q;
      irq_vblank_d = 1'b0;
      lyc_eq_d     = (ly_q == bus.lyc);

      if (!bus.lcd_en) begin
         dot_d  = '0;
         ly_d   = '0;
         mode_d = HBLANK;
         run_d  = 1'b0;
      end else if (!run_q) begin
         // first enabled clk: park at the start of line 0
         dot_d  = '0;
         ly_d   = '0;
         mode_d = OAM;
         run_d  = 1'b1;
      end else begin
         irq_vblank_d = (ly_q == LY_W'(VISIBLE_LINES)) && (dot_q == '0);

         if (dot_q == DOT_W'(DOTS_PER_LINE - 1)) begin
            dot_d = '0;
            ly_d  = (ly_q == LY_W'(LINES_PER_FRAME - 1)) ? '0 : ly_q + LY_W'(1);
         end else begin
            dot_d = dot_q + DOT_W'(1);
         end

         if (ly_d >= LY_W'(VISIBLE_LINES)) begin
            mode_d = VBLANK;
         end else if (dot_d < DOT_W'(OAM_DOTS)) begin
            mode_d = OAM;
         end else begin
            // pen is latched on entry to DRAW and held for the rest of the line
            if (dot_d == DOT_W'(OAM_DOTS)) begin
               pen_d = bus.scx_lo;
            end
            mode_d = (dot_d < DOT_W'(DRAW_END) + DOT_W'(pen_d)) ? DRAW : HBLANK;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dot_q        <= '0;
         ly_q         <= '0;
         mode_q       <= HBLANK;
         pen_q        <= '0;
         run_q        <= 1'b0;
         lyc_eq_q     <= 1'b0;
         irq_vblank_q <= 1'b0;
      end else begin
         dot_q        <= dot_d;
         ly_q         <= ly_d;
         mode_q       <= mode_d;
         pen_q        <= pen_d;
         run_q        <= run_d;
         lyc_eq_q     <= lyc_eq_d;
         irq_vblank_q <= irq_vblank_d;
      end
   end

   // STAT line from the registered mode/flag as seen by software
   assign stat_line_c = (bus.stat_ie[0] & (mode_q == HBLANK)) |
                        (bus.stat_ie[1] & (mode_q == VBLANK)) |
                        (bus.stat_ie[2] & (mode_q == OAM))    |
                        (bus.stat_ie[3] & lyc_eq_q);

   // History stays cleared while disabled and on the restart clk, so the
   // parked HBLANK state never counts as a prior high level.
   assign stat_clr_c = ~(bus.lcd_en & run_q);

   lcd_stat_irq u_stat_irq (
      .clk       (clk),
      .reset     (reset),
      .stat_line (stat_line_c),
      .clr       (stat_clr_c),
      .pulse     (irq_stat_c)
   );

   assign bus.dot        = dot_q;
   assign bus.ly         = ly_q;
   assign bus.mode       = mode_q;
   assign bus.lyc_eq     = lyc_eq_q;
   assign bus.irq_vblank = irq_vblank_q;
   assign bus.irq_stat   = irq_stat_c;

endmodule
